// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix result serializer.
//   W      element width in bits
//   DIM    matrix dimension; N = DIM*DIM elements per matrix
//   IDX_W  width of the element index counter
//   RC_W   width of the row/column indices (wide enough for the value 3)
//   state_e  serializer FSM states
package matrix_pkg;

    localparam int unsigned W     = 16;
    localparam int unsigned DIM   = 3;
    localparam int unsigned N     = DIM * DIM;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned RC_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_e;

endpackage

// File: rtl/matrix_elem_select.sv
// Combinational N:1 element selector over a flat matrix.
// Ports:
//   shadow  in  N*W    flat matrix, element k = shadow[k*W +: W]
//   idx     in  IDX_W  element index (row-major)
//   elem    out W      selected element; 0 for out-of-range indices
module matrix_elem_select
    import matrix_pkg::*;
(
    input  logic [N*W-1:0] shadow,
    input  logic [IDX_W-1:0] idx,
    output logic [W-1:0]   elem
);

    always_comb begin
        elem = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) begin
                elem = shadow[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/matrix_result_serializer.sv
// Captures a flat DIM x DIM result matrix in one cycle and streams its
// elements row-major over a valid/ready interface.
// Optional feature: define CHECKSUM_EN to append an XOR checksum word
// (row = col = 3) after the last element; out_last then moves to it.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   load       in   capture request, honoured only in IDLE
//   mat_in     in   flat matrix, element k = mat_in[k*W +: W]
//   busy       out  frame in progress
//   out_data   out  current element
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts the current word
//   out_row    out  row index of out_data
//   out_col    out  column index of out_data
//   out_last   out  final word of the frame
//   overrun    out  one-cycle pulse after a load arrives while busy
module matrix_result_serializer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [N*W-1:0]    mat_in,
    output logic              busy,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RC_W-1:0]   out_row,
    output logic [RC_W-1:0]   out_col,
    output logic              out_last,
    output logic              overrun
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RC_W-1:0]    row_q, row_d;
    logic [RC_W-1:0]    col_q, col_d;
    logic [N*W-1:0]     shadow_q, shadow_d;
    logic               overrun_q, overrun_d;

    logic [W-1:0]       elem;
    logic               xfer;
    logic               idx_end;

    matrix_elem_select u_sel (
        .shadow (shadow_q),
        .idx    (idx_q),
        .elem   (elem)
    );

`ifdef CHECKSUM_EN
    logic [W-1:0] csum;

    always_comb begin
        csum = '0;
        for (int unsigned k = 0; k < N; k++) begin
            csum = csum ^ shadow_q[k*W +: W];
        end
    end
`endif

    // Valid depends only on registered state, never on out_ready.
    assign out_valid = (state_q != IDLE);
    assign busy      = out_valid;
    assign xfer      = out_valid & out_ready;
    assign idx_end   = (idx_q == IDX_W'(N - 1));
    assign overrun   = overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            shadow_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            shadow_q  <= shadow_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        shadow_d  = shadow_q;
        // Any load outside IDLE is dropped, including on the final transfer.
        overrun_d = load && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d  = SEND;
                    shadow_d = mat_in;
                    idx_d    = '0;
                    row_d    = '0;
                    col_d    = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_end) begin
                        idx_d = '0;
                        row_d = '0;
                        col_d = '0;
`ifdef CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == RC_W'(DIM - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_data = '0;
        out_row  = '0;
        out_col  = '0;
        out_last = 1'b0;
        case (state_q)
            SEND: begin
                out_data = elem;
                out_row  = row_q;
                out_col  = col_q;
`ifndef CHECKSUM_EN
                out_last = idx_end;
`endif
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                out_data = csum;
                out_row  = RC_W'(3);
                out_col  = RC_W'(3);
                out_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed self-checking bench for matrix_result_serializer.
module tb_matrix_result_serializer;
    import matrix_pkg::*;

`ifdef CHECKSUM_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    logic              clk;
    logic              rst;
    logic              load;
    logic [N*W-1:0]    mat_in;
    logic              busy;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [RC_W-1:0]   out_row;
    logic [RC_W-1:0]   out_col;
    logic              out_last;
    logic              overrun;

    int checks = 0;
    int passed = 0;

    int unsigned a_vals [N] = '{132, 17, 129, 9, 3, 2, 6, 16, 514};
    int unsigned b_vals [N] = '{1000, 2001, 3002, 4003, 5004, 6005, 7006, 8007, 9008};
    logic [N*W-1:0] mat_a;
    logic [N*W-1:0] mat_b;

    matrix_result_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .mat_in    (mat_in),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input logic [N*W-1:0] m, input int w);
        logic [W-1:0] x;
        x = '0;
        if (w < int'(N)) return m[w*W +: W];
        for (int k = 0; k < int'(N); k++) x = x ^ m[k*W +: W];
        return x;
    endfunction

    function automatic logic [31:0] exp_row(input int w);
        return (w < int'(N)) ? 32'(w / int'(DIM)) : 32'd3;
    endfunction

    function automatic logic [31:0] exp_col(input int w);
        return (w < int'(N)) ? 32'(w % int'(DIM)) : 32'd3;
    endfunction

    // Called at a negedge. Loads m, then swaps mat_in to m2 so a late change
    // on mat_in would show up as wrong data. rmode 0: ready always high;
    // rmode 1: ready pattern 1,0,0,1,0,0... ovr_word >= 0 fires one extra
    // load while that word is presented.
    task automatic run_frame(input string name, input logic [N*W-1:0] m, input int rmode,
                             input int ovr_word, input logic [N*W-1:0] m2);
        int  w;
        int  c;
        bit  fired;
        bit  fire;
        bit  exp_ovr;
        w = 0; c = 0; fired = 0; exp_ovr = 0;
        mat_in = m;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        mat_in = m2;
        while (w < FRAME && c < 200) begin
            out_ready = (rmode == 0) ? 1'b1 : ((c % 3) == 0);
            check($sformatf("%s valid w%0d", name, w), 32'(out_valid), 32'd1);
            check($sformatf("%s busy w%0d", name, w), 32'(busy), 32'd1);
            check($sformatf("%s data w%0d", name, w), 32'(out_data), 32'(exp_word(m, w)));
            check($sformatf("%s row w%0d", name, w), 32'(out_row), exp_row(w));
            check($sformatf("%s col w%0d", name, w), 32'(out_col), exp_col(w));
            check($sformatf("%s last w%0d", name, w), 32'(out_last), 32'(w == FRAME - 1));
            check($sformatf("%s overrun c%0d", name, c), 32'(overrun), 32'(exp_ovr));
            fire = (ovr_word >= 0) && (w == ovr_word) && !fired;
            if (fire) begin
                load  = 1'b1;
                fired = 1'b1;
            end
            exp_ovr = fire;
            if (out_ready) w++;
            c++;
            @(negedge clk);
            load = 1'b0;
        end
        check($sformatf("%s frame completed in budget", name), 32'(c < 200), 32'd1);
        check($sformatf("%s valid after end", name), 32'(out_valid), 32'd0);
        check($sformatf("%s busy after end", name), 32'(busy), 32'd0);
        check($sformatf("%s overrun after end", name), 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        for (int k = 0; k < int'(N); k++) begin
            mat_a[k*W +: W] = W'(a_vals[k]);
            mat_b[k*W +: W] = W'(b_vals[k]);
        end
        rst = 1'b1; load = 1'b0; out_ready = 1'b0; mat_in = '0;

        // Reset values
        @(negedge clk);
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst last", 32'(out_last), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst data", 32'(out_data), 32'd0);
        check("rst row", 32'(out_row), 32'd0);
        check("rst col", 32'(out_col), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle valid", 32'(out_valid), 32'd0);
        end

        // Basic frame, ready held high
        run_frame("basic", mat_a, 0, -1, mat_b);
        // Backpressure
        run_frame("bp", mat_a, 1, -1, mat_b);
        // Overrun at word 3
        run_frame("ovr", mat_a, 0, 3, mat_b);
        // Load during final transfer is ignored, load one cycle later accepted
        run_frame("edge", mat_a, 0, FRAME - 1, mat_b);
        run_frame("after", mat_b, 0, -1, mat_a);

        // Asynchronous reset mid-frame at idx 4
        mat_in = mat_a;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("mid idx4 data", 32'(out_data), 32'd3);
        check("mid idx4 row", 32'(out_row), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async valid", 32'(out_valid), 32'd0);
        check("async busy", 32'(busy), 32'd0);
        check("async data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post-rst idle valid", 32'(out_valid), 32'd0);
            check("post-rst idle busy", 32'(busy), 32'd0);
        end
        run_frame("recover", mat_a, 0, -1, mat_b);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
